multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//  Sequencer that sits on both sides of the N-bit ripple adder (FullAdderN). It accepts
//  one WIDE operand pair (WORDS*N bits) per transaction. It drives the adder one N-bit word
//  per cycle, LSW first, and feeds each registered c_out back as the next word's c_in.
//  It collects the sums into a WIDE result and returns it over a valid/ready handshake.
//  The adder is instantiated alongside (not inside) this block.
// PARAMETERS
//  N       4   adder word width; must match the connected adder
//  WORDS   4   words per operand; >=1; operand width WIDE = WORDS*N
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-high
//  in_valid    in   1      operand pair offered
//  in_ready    out  1      block can accept an operand pair
//  op_a        in   WIDE   operand A
//  op_b        in   WIDE   operand B
//  op_cin      in   1      carry into word 0
//  add_a       out  N      to adder a
//  add_b       out  N      to adder b
//  add_c_in    out  1      to adder c_in
//  add_sum     in   N      from adder sum (combinational in add_a/add_b/add_c_in)
//  add_c_out   in   1      from adder c_out
//  out_valid   out  1      result available
//  out_ready   in   1      consumer takes result
//  result      out  WIDE   sum of op_a + op_b + op_cin, modulo 2^WIDE
//  result_cout out  1      unsigned carry out of the top word
//  result_ovf  out  1      two's-complement overflow of the WIDE add
// BEHAVIOUR
//  - FSM states: IDLE, RUN, DONE. On reset: IDLE, in_ready=1, out_valid=0, result=0,
//    result_cout=0, result_ovf=0, idx=0, carry reg=0, add_a/add_b/add_c_in=0.
//  - IDLE: in_ready=1. On in_valid&in_ready, latch op_a/op_b into internal regs,
//    set carry reg=op_cin, set idx=0, go to RUN.
//  - RUN: in_ready=0. Drive add_a=a_reg[idx*N+:N], add_b=b_reg[idx*N+:N], add_c_in=carry reg.
//    Each cycle, capture add_sum into result[idx*N+:N] and add_c_out into carry reg.
//    At idx==WORDS-1 also capture result_cout=add_c_out and
//    result_ovf=(a_msb==b_msb)&&(add_sum[N-1]!=a_msb), then go to DONE. Otherwise idx++.
//  - Adder outputs are sampled in the same cycle that its inputs are driven (one pure
//    combinational path). In IDLE and DONE, adder inputs are driven to 0.
//  - DONE: out_valid=1. result, result_cout and result_ovf stay stable until
//    out_valid&out_ready. Then go to IDLE (in_ready=1 on the next cycle; no back-to-back
//    bypass).
//  - Latency: accept edge -> out_valid high after exactly WORDS+1 clock edges.
//    Throughput: one transaction per WORDS+2 cycles when out_ready is held at 1.
//  - WORDS==1: RUN lasts one cycle; idx stays 0.
//  - in_valid during RUN/DONE: ignored, because in_ready=0. The upstream source holds its
//    operands.
//  - out_ready while not in DONE: no effect.
//  - rst mid-RUN or mid-DONE: abort on that edge and apply the full reset state. The partial
//    result is discarded; out_valid is never asserted for the aborted transaction.
//  - idx width = clog2(WORDS) (min 1). It never wraps past WORDS-1.
// STRUCTURE
//  - Shared package: state enum {IDLE,RUN,DONE}; localparam WIDE=WORDS*N; IDX_W.
//  - No sub-module. One FSM plus a datapath register block. Top-level integration pairs
//    this block with FullAdderN (N matched); that integration is covered by the bench below.
// TESTING  (N=4, WORDS=4, bench instantiates FullAdderN as the adder)
//  1. Reset, then op_a=0x1234, op_b=0x4321, op_cin=0 -> result=0x5555, cout=0, ovf=0,
//     out_valid on cycle 5 after accept.
//  2. op_a=0xFFFF, op_b=0x0000, op_cin=1 -> carry ripples through all words:
//     result=0x0000, cout=1, ovf=0.
//  3. op_a=0x7FFF, op_b=0x0001, cin=0 -> result=0x8000, cout=0, ovf=1;
//     op_a=0x8000, op_b=0x8000 -> result=0x0000, cout=1, ovf=1.
//  4. Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid
//     ignored. Release -> IDLE next cycle, the queued pair is then accepted.
//  5. Assert rst at RUN idx=2 -> next cycle IDLE with all outputs zero. The next transaction
//     0x0001+0x0001 -> 0x0002.
//  6. WORDS=1 build: 0xF+0x1 -> result=0x0, cout=1, latency 2. Plus 200 random vectors
//     checked against a reference model of {cout,result}=op_a+op_b+op_cin.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared types and sizing helpers for the multi-word add sequencer.
// Module-level N/WORDS override the defaults; the defaults document the reference build.
package multiword_add_seq_pkg;

   localparam int DEF_N     = 4;
   localparam int DEF_WORDS = 4;
   localparam int WIDE      = DEF_WORDS * DEF_N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Word index needs at least one bit even when only one word exists.
   function automatic int idx_width(input int words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

   localparam int IDX_W = idx_width(DEF_WORDS);

endpackage

// File: rtl/full_adder_n.sv
// N-bit ripple-carry adder paired with multiword_add_seq at integration level.
// Purely combinational: sum/c_out settle from a, b and c_in in the same cycle.
module FullAdderN #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);

   logic [N:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = c_in;
      for (int i = 0; i < N; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign c_out = carry[N];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequences a WIDE add through an external N-bit adder, one word per cycle, LSW first,
// chaining carry through a register, and returns the result over valid/ready.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// in_valid/in_ready take an operand pair; out_valid/out_ready hand back the result.
// The producer holds its data stable while valid is high and ready is low.
module multiword_add_seq
   import multiword_add_seq_pkg::*;
#(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORDS*N-1:0]   op_a,
   input  logic [WORDS*N-1:0]   op_b,
   input  logic                 op_cin,
   output logic [N-1:0]         add_a,
   output logic [N-1:0]         add_b,
   output logic                 add_c_in,
   input  logic [N-1:0]         add_sum,
   input  logic                 add_c_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORDS*N-1:0]   result,
   output logic                 result_cout,
   output logic                 result_ovf,
   output logic [1:0]           dbg_state
);

   localparam int W_WIDE = WORDS * N;
   localparam int W_IDX  = idx_width(WORDS);

   state_e              state_q, state_d;
   logic [W_IDX-1:0]    idx_q, idx_d;
   logic                carry_q, carry_d;
   logic [W_WIDE-1:0]   a_q, a_d;
   logic [W_WIDE-1:0]   b_q, b_d;
   logic [W_WIDE-1:0]   result_q, result_d;
   logic                cout_q, cout_d;
   logic                ovf_q, ovf_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic                last_word;

   assign last_word = (int'(idx_q) == WORDS - 1);

   // Adder inputs are live only while running; zero elsewhere keeps the adder quiet.
   always_comb begin
      add_a    = '0;
      add_b    = '0;
      add_c_in = 1'b0;
      if (state_q == RUN) begin
         add_a    = a_q[int'(idx_q) * N +: N];
         add_b    = b_q[int'(idx_q) * N +: N];
         add_c_in = carry_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = op_a;
               b_d        = op_b;
               carry_d    = op_cin;
               idx_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end

         RUN: begin
            result_d[int'(idx_q) * N +: N] = add_sum;
            carry_d = add_c_out;
            if (last_word) begin
               // Signed overflow: like-signed operands producing an opposite-signed sum.
               cout_d      = add_c_out;
               ovf_d       = (a_q[W_WIDE-1] == b_q[W_WIDE-1]) &&
                             (add_sum[N-1] != a_q[W_WIDE-1]);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               idx_d = idx_q + W_IDX'(1);
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign result_cout = cout_q;
   assign result_ovf  = ovf_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq paired with FullAdderN: a 4-word build and a 1-word build.
module tb_multiword_add_seq;

   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int WIDE  = N * WORDS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // 4-word build
   logic            in_valid = 1'b0, in_ready, op_cin = 1'b0;
   logic [WIDE-1:0] op_a = '0, op_b = '0, result;
   logic [N-1:0]    add_a, add_b, add_sum;
   logic            add_c_in, add_c_out;
   logic            out_valid, out_ready = 1'b1, result_cout, result_ovf;
   logic [1:0]      dbg_state;

   // 1-word build
   logic            in_valid_1 = 1'b0, in_ready_1, op_cin_1 = 1'b0;
   logic [N-1:0]    op_a_1 = '0, op_b_1 = '0, result_1;
   logic [N-1:0]    add_a_1, add_b_1, add_sum_1;
   logic            add_c_in_1, add_c_out_1;
   logic            out_valid_1, out_ready_1 = 1'b1, result_cout_1, result_ovf_1;
   logic [1:0]      dbg_state_1;

   int n_checks = 0;
   int n_err    = 0;

   logic [WIDE+1:0] exp_q[$];

   typedef struct {
      logic [WIDE-1:0] a;
      logic [WIDE-1:0] b;
      logic            cin;
      logic [WIDE-1:0] exp_r;
      logic            exp_co;
      logic            exp_ovf;
   } vec_t;

   vec_t vecs[6];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
      .add_sum(add_sum), .add_c_out(add_c_out),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_cout(result_cout), .result_ovf(result_ovf),
      .dbg_state(dbg_state)
   );

   FullAdderN #(.N(N)) adder (
      .a(add_a), .b(add_b), .c_in(add_c_in), .sum(add_sum), .c_out(add_c_out)
   );

   multiword_add_seq #(.N(N), .WORDS(1)) dut_1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_1), .in_ready(in_ready_1),
      .op_a(op_a_1), .op_b(op_b_1), .op_cin(op_cin_1),
      .add_a(add_a_1), .add_b(add_b_1), .add_c_in(add_c_in_1),
      .add_sum(add_sum_1), .add_c_out(add_c_out_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1),
      .result(result_1), .result_cout(result_cout_1), .result_ovf(result_ovf_1),
      .dbg_state(dbg_state_1)
   );

   FullAdderN #(.N(N)) adder_1 (
      .a(add_a_1), .b(add_b_1), .c_in(add_c_in_1), .sum(add_sum_1), .c_out(add_c_out_1)
   );

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Called and returns at posedge+1; leaves the DUT in IDLE with out_ready held high.
   task automatic send(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b, input logic cin,
                       output logic [WIDE-1:0] r, output logic co, output logic ovf,
                       output int lat);
      int guard;
      op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      r = result; co = result_cout; ovf = result_ovf;
      @(posedge clk); #1;
   endtask

   task automatic send_1(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         output logic [N-1:0] r, output logic co, output logic ovf,
                         output int lat);
      int guard;
      op_a_1 = a; op_b_1 = b; op_cin_1 = cin; in_valid_1 = 1'b1;
      guard = 0;
      while (!in_ready_1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      lat = 1;
      while (!out_valid_1 && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      r = result_1; co = result_cout_1; ovf = result_ovf_1;
      @(posedge clk); #1;
   endtask

   // ---------------- test ----------------
   initial begin
      logic [WIDE-1:0] r;
      logic [N-1:0]    r1;
      logic            co, ovf;
      int              lat, guard;
      logic [WIDE-1:0] ra, rb;
      logic            rc;
      logic [WIDE:0]   full;
      logic [WIDE+1:0] exp_v;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset cout_ovf", 32'({result_cout, result_ovf}), 32'd0);
      check("reset adder_in", 32'({add_a, add_b, add_c_in}), 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].cin, r, co, ovf, lat);
         check($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].exp_r));
         check($sformatf("vec%0d cout", i), 32'(co), 32'(vecs[i].exp_co));
         check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(WORDS + 1));
      end

      // Back-pressure in DONE with a second pair waiting
      out_ready = 1'b0;
      op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("bp first result", 32'(result), 32'h3333);
      op_a = 16'h0005; op_b = 16'h0003; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp hold result", 32'(result), 32'h3333);
         check("bp hold flags", 32'({out_valid, in_ready}), 32'b10);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release idle", 32'({out_valid, in_ready, dbg_state}), 32'b01_00);
      @(posedge clk); #1;
      check("bp queued accept", 32'({in_ready, dbg_state}), 32'b0_01);
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("bp queued result", 32'(result), 32'h0008);
      @(posedge clk); #1;

      // Reset in the middle of RUN at word 2
      op_a = 16'hABCD; op_b = 16'h5555; op_cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid-run word2 add_a", 32'({dbg_state, add_a}), 32'h1B);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort flags", 32'({out_valid, in_ready, dbg_state}), 32'b01_00);
      check("abort result", 32'(result), 32'd0);
      check("abort cout_ovf", 32'({result_cout, result_ovf}), 32'd0);
      check("abort adder_in", 32'({add_a, add_b, add_c_in}), 32'd0);
      send(16'h0001, 16'h0001, 1'b0, r, co, ovf, lat);
      check("post-abort result", 32'(r), 32'h0002);
      check("post-abort latency", 32'(lat), 32'(WORDS + 1));

      // 1-word build
      send_1(4'hF, 4'h1, 1'b0, r1, co, ovf, lat);
      check("w1 F+1 result", 32'(r1), 32'h0);
      check("w1 F+1 cout_ovf", 32'({co, ovf}), 32'b10);
      check("w1 F+1 latency", 32'(lat), 32'd2);
      send_1(4'h7, 4'h0, 1'b1, r1, co, ovf, lat);
      check("w1 7+0+1 result", 32'(r1), 32'h8);
      check("w1 7+0+1 cout_ovf", 32'({co, ovf}), 32'b01);

      // Random vectors against a reference model
      for (int i = 0; i < 200; i++) begin
         ra = WIDE'($urandom_range(0, 65535));
         rb = WIDE'($urandom_range(0, 65535));
         rc = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {{WIDE{1'b0}}, rc};
         exp_q.push_back({(ra[WIDE-1] == rb[WIDE-1]) && (full[WIDE-1] != ra[WIDE-1]),
                          full[WIDE], full[WIDE-1:0]});
         send(ra, rb, rc, r, co, ovf, lat);
         exp_v = exp_q.pop_front();
         check($sformatf("rand%0d {ovf,cout,result}", i), 32'({ovf, co, r}), 32'(exp_v));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, required finish before limit");
      $fatal(1, "timeout");
   end

endmodule
